// File: rtl/usb_pkt_tx.sv
// usb_pkt_tx: USB full-speed packet transmitter (handshake, token and data).
// Serialises SYNC, PID, token field or payload, then CRC5/CRC16. Bit stuffing
// and NRZI are applied to the line, and every packet ends with SE0, SE0, J.
// One line bit is driven per clock.
// Optional feature macro: DATA_TOGGLE_EN. It adds toggle_adv/toggle_clr and an
// internal DATA0/DATA1 toggle bit that supplies the PID of data packets.
//
// Request handshake: a request transfers on the rising clock edge where
// req_valid && req_ready. req_ready is high only while the block is idle. All
// request fields are captured on that edge. A requester that sees
// req_ready low must hold req_valid and the fields stable until the transfer.
module usb_pkt_tx #(
    parameter int         MAX_BYTES = 8,
    parameter logic [6:0] DEV_ADDR  = 7'd5,
    parameter int         LEN_W     = $clog2(MAX_BYTES + 1)
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [1:0]             req_kind,
    input  logic [3:0]             req_pid,
    input  logic [3:0]             req_endp,
    input  logic [LEN_W-1:0]       req_len,
    input  logic [8*MAX_BYTES-1:0] req_data,
`ifdef DATA_TOGGLE_EN
    input  logic                   toggle_adv,
    input  logic                   toggle_clr,
`endif
    output logic                   DP,
    output logic                   DM,
    output logic                   busy,
    output logic                   done,
    output logic [3:0]             dbg_state_o
);

    localparam int BITS  = 8 * MAX_BYTES;
    // Field bit counter must hold the largest field length minus one (>= 15).
    localparam int CNT_W = (BITS > 16) ? $clog2(BITS) : 4;
    localparam int DBW   = LEN_W + 3;

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_SYNC    = 4'd1,
        S_PID     = 4'd2,
        S_TOKEN   = 4'd3,
        S_CRC5    = 4'd4,
        S_DATA    = 4'd5,
        S_CRC16   = 4'd6,
        S_EOP_SE0 = 4'd7,
        S_EOP_J   = 4'd8
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         kind_q, kind_d;
    logic [7:0]         pid_q, pid_d;
    logic [10:0]        tok_q, tok_d;
    logic [BITS-1:0]    data_q, data_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [4:0]         crc5_q, crc5_d;
    logic [15:0]        crc16_q, crc16_d;
    logic [2:0]         stuff_q, stuff_d;
    logic               nrzi_q, nrzi_d;

    logic               in_field;
    logic               stall;
    logic               field_bit;
    logic               tx_bit;
    logic               level;
    logic [3:0]         pid_nib;
    logic [DBW-1:0]     data_bits_m1;

`ifdef DATA_TOGGLE_EN
    logic               toggle_q, toggle_d;

    // Toggle bit: clear wins over advance; sampled only when a request is accepted.
    always_comb begin
        toggle_d = toggle_q;
        if (toggle_clr) begin
            toggle_d = 1'b0;
        end else if (toggle_adv) begin
            toggle_d = ~toggle_q;
        end
    end

    // Toggle bit register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            toggle_q <= 1'b0;
        end else begin
            toggle_q <= toggle_d;
        end
    end

    // Data packets take their PID from the toggle bit (DATA0/DATA1).
    always_comb begin
        pid_nib = req_pid;
        if (req_kind == 2'b10) begin
            pid_nib = toggle_q ? 4'b1011 : 4'b0011;
        end
    end
`else
    // PID nibble always comes from the request.
    always_comb begin
        pid_nib = req_pid;
    end
`endif

    // Current pre-NRZI bit: a stuffed 0 when six ones were just sent, else the field bit.
    always_comb begin
        in_field  = (state_q != S_IDLE) && (state_q != S_EOP_SE0) && (state_q != S_EOP_J);
        stall     = (stuff_q == 3'd6) && (state_q != S_IDLE) && (state_q != S_EOP_J);
        field_bit = 1'b0;
        case (state_q)
            S_SYNC:  field_bit = (cnt_q == '0);
            S_PID:   field_bit = pid_q[0];
            S_TOKEN: field_bit = tok_q[0];
            S_CRC5:  field_bit = ~crc5_q[4];
            S_DATA:  field_bit = data_q[0];
            S_CRC16: field_bit = ~crc16_q[15];
            default: field_bit = 1'b0;
        endcase
        tx_bit = field_bit & ~stall;
        // NRZI: a 0 flips the line, a 1 holds it (1 = J level).
        level  = tx_bit ? nrzi_q : ~nrzi_q;
    end

    // Line drivers: SE0 during EOP (after any owed stuff bit), J when idle.
    always_comb begin
        DP = 1'b1;
        DM = 1'b0;
        if ((state_q == S_EOP_SE0) && !stall) begin
            DP = 1'b0;
            DM = 1'b0;
        end else if (in_field || stall) begin
            DP = level;
            DM = ~level;
        end
    end

    // Status outputs decoded from the state.
    always_comb begin
        req_ready   = (state_q == S_IDLE);
        busy        = (state_q != S_IDLE);
        done        = (state_q == S_EOP_J);
        dbg_state_o = state_q;
    end

    // Next state and field datapath; the field shift stalls on stuff cycles.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        kind_d       = kind_q;
        pid_d        = pid_q;
        tok_d        = tok_q;
        data_d       = data_q;
        len_d        = len_q;
        crc5_d       = crc5_q;
        crc16_d      = crc16_q;
        stuff_d      = 3'd0;
        nrzi_d       = nrzi_q;
        data_bits_m1 = {len_q, 3'b000} - DBW'(1);

        if (stall || in_field) begin
            nrzi_d = level;
        end
        if (!stall && in_field && tx_bit) begin
            stuff_d = stuff_q + 3'd1;
        end

        case (state_q)
            S_IDLE: begin
                nrzi_d = 1'b1;
                if (req_valid) begin
                    state_d = S_SYNC;
                    cnt_d   = CNT_W'(7);
                    kind_d  = (req_kind == 2'b11) ? 2'b00 : req_kind;
                    pid_d   = {~pid_nib, pid_nib};
                    tok_d   = {req_endp, DEV_ADDR};
                    data_d  = req_data;
                    len_d   = (req_len > LEN_W'(MAX_BYTES)) ? LEN_W'(MAX_BYTES) : req_len;
                    crc5_d  = 5'h1f;
                    crc16_d = 16'hffff;
                end
            end
            S_SYNC: begin
                if (!stall) begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == '0) begin
                        state_d = S_PID;
                        cnt_d   = CNT_W'(7);
                    end
                end
            end
            S_PID: begin
                if (!stall) begin
                    pid_d = {1'b0, pid_q[7:1]};
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == '0) begin
                        if (kind_q == 2'b01) begin
                            state_d = S_TOKEN;
                            cnt_d   = CNT_W'(10);
                        end else if (kind_q == 2'b10) begin
                            if (len_q == '0) begin
                                state_d = S_CRC16;
                                cnt_d   = CNT_W'(15);
                            end else begin
                                state_d = S_DATA;
                                cnt_d   = CNT_W'(data_bits_m1);
                            end
                        end else begin
                            state_d = S_EOP_SE0;
                            cnt_d   = CNT_W'(1);
                        end
                    end
                end
            end
            S_TOKEN: begin
                if (!stall) begin
                    tok_d  = {1'b0, tok_q[10:1]};
                    crc5_d = {crc5_q[3:0], 1'b0} ^ ((tok_q[0] ^ crc5_q[4]) ? 5'b00101 : 5'b00000);
                    cnt_d  = cnt_q - CNT_W'(1);
                    if (cnt_q == '0) begin
                        state_d = S_CRC5;
                        cnt_d   = CNT_W'(4);
                    end
                end
            end
            S_CRC5: begin
                if (!stall) begin
                    crc5_d = {crc5_q[3:0], 1'b0};
                    cnt_d  = cnt_q - CNT_W'(1);
                    if (cnt_q == '0) begin
                        state_d = S_EOP_SE0;
                        cnt_d   = CNT_W'(1);
                    end
                end
            end
            S_DATA: begin
                if (!stall) begin
                    data_d  = {1'b0, data_q[BITS-1:1]};
                    crc16_d = {crc16_q[14:0], 1'b0} ^ ((data_q[0] ^ crc16_q[15]) ? 16'h8005 : 16'h0000);
                    cnt_d   = cnt_q - CNT_W'(1);
                    if (cnt_q == '0) begin
                        state_d = S_CRC16;
                        cnt_d   = CNT_W'(15);
                    end
                end
            end
            S_CRC16: begin
                if (!stall) begin
                    crc16_d = {crc16_q[14:0], 1'b0};
                    cnt_d   = cnt_q - CNT_W'(1);
                    if (cnt_q == '0) begin
                        state_d = S_EOP_SE0;
                        cnt_d   = CNT_W'(1);
                    end
                end
            end
            S_EOP_SE0: begin
                // A stuff bit owed by the last CRC bit goes out before SE0 starts.
                if (!stall) begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == '0) begin
                        state_d = S_EOP_J;
                    end
                end
            end
            S_EOP_J: begin
                state_d = S_IDLE;
                nrzi_d  = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset returns the line to J immediately.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            kind_q  <= 2'b00;
            pid_q   <= 8'h00;
            tok_q   <= 11'h000;
            data_q  <= '0;
            len_q   <= '0;
            crc5_q  <= 5'h1f;
            crc16_q <= 16'hffff;
            stuff_q <= 3'd0;
            nrzi_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            kind_q  <= kind_d;
            pid_q   <= pid_d;
            tok_q   <= tok_d;
            data_q  <= data_d;
            len_q   <= len_d;
            crc5_q  <= crc5_d;
            crc16_q <= crc16_d;
            stuff_q <= stuff_d;
            nrzi_q  <= nrzi_d;
        end
    end

endmodule

// File: tb/tb_usb_pkt_tx.sv
// tb_usb_pkt_tx: self-checking bench for usb_pkt_tx.
// A reference model builds each packet's expected line symbols (SYNC, PID,
// field, CRC, stuffing, NRZI, EOP) from the packet rules; the bench compares
// DP/DM/busy/done/req_ready every cycle. Build with +define+DATA_TOGGLE_EN to
// also exercise the DATA0/DATA1 toggle.
module tb_usb_pkt_tx;

    localparam int         TB_MAX  = 8;
    localparam logic [6:0] TB_ADDR = 7'd5;
    localparam int         LEN_W   = $clog2(TB_MAX + 1);
    localparam int         DW      = 8 * TB_MAX;

    // ---------------- clock / reset ----------------
    logic             clock;
    logic             reset_n;
    logic             req_valid;
    logic             req_ready;
    logic [1:0]       req_kind;
    logic [3:0]       req_pid;
    logic [3:0]       req_endp;
    logic [LEN_W-1:0] req_len;
    logic [DW-1:0]    req_data;
    logic             DP;
    logic             DM;
    logic             busy;
    logic             done;
    logic [3:0]       dbg_state;
`ifdef DATA_TOGGLE_EN
    logic             toggle_adv;
    logic             toggle_clr;
`endif

    initial clock = 1'b0;
    always #5 clock = ~clock;

    usb_pkt_tx #(
        .MAX_BYTES(TB_MAX),
        .DEV_ADDR (TB_ADDR)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_kind   (req_kind),
        .req_pid    (req_pid),
        .req_endp   (req_endp),
        .req_len    (req_len),
        .req_data   (req_data),
`ifdef DATA_TOGGLE_EN
        .toggle_adv (toggle_adv),
        .toggle_clr (toggle_clr),
`endif
        .DP         (DP),
        .DM         (DM),
        .busy       (busy),
        .done       (done),
        .dbg_state_o(dbg_state)
    );

    // ---------------- scoreboard ----------------
    logic [1:0] exp_q[$];     // expected {DP,DM} per busy cycle
    int         n_cmp = 0;
    int         n_err = 0;
    logic       mdl_tog = 1'b0;

    // staged fields presented while the previous packet is still busy
    logic [1:0]       stage_kind;
    logic [3:0]       stage_pid;
    logic [3:0]       stage_endp;
    logic [LEN_W-1:0] stage_len;
    logic [DW-1:0]    stage_data;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [4:0] crc5_next(input logic [4:0] c, input logic b);
        return {c[3:0], 1'b0} ^ ((b ^ c[4]) ? 5'b00101 : 5'b00000);
    endfunction

    function automatic logic [15:0] crc16_next(input logic [15:0] c, input logic b);
        return {c[14:0], 1'b0} ^ ((b ^ c[15]) ? 16'h8005 : 16'h0000);
    endfunction

    // Reference model: expected line symbols for one packet, appended to exp_q.
    task automatic build_expected(input logic [1:0] kind, input logic [3:0] pid,
                                  input logic [3:0] endp, input int len,
                                  input logic [DW-1:0] data);
        bit          raw[$];
        bit          stf[$];
        logic [1:0]  k;
        logic [3:0]  pn;
        logic [7:0]  pb;
        logic [10:0] tok;
        logic [4:0]  c5;
        logic [15:0] c16;
        int          n;
        int          ones;
        logic        lvl;
        k  = (kind == 2'b11) ? 2'b00 : kind;
        pn = pid;
`ifdef DATA_TOGGLE_EN
        if (k == 2'b10) pn = mdl_tog ? 4'b1011 : 4'b0011;
`endif
        pb = {~pn, pn};
        for (int i = 0; i < 7; i++) raw.push_back(1'b0);
        raw.push_back(1'b1);
        for (int i = 0; i < 8; i++) raw.push_back(pb[i]);
        if (k == 2'b01) begin
            tok = {endp, TB_ADDR};
            c5  = 5'h1f;
            for (int i = 0; i < 11; i++) begin
                raw.push_back(tok[i]);
                c5 = crc5_next(c5, tok[i]);
            end
            for (int i = 4; i >= 0; i--) raw.push_back(~c5[i]);
        end else if (k == 2'b10) begin
            n   = (len > TB_MAX) ? TB_MAX : len;
            c16 = 16'hffff;
            for (int i = 0; i < 8 * n; i++) begin
                raw.push_back(data[i]);
                c16 = crc16_next(c16, data[i]);
            end
            for (int i = 15; i >= 0; i--) raw.push_back(~c16[i]);
        end
        ones = 0;
        foreach (raw[i]) begin
            stf.push_back(raw[i]);
            ones = raw[i] ? ones + 1 : 0;
            if (ones == 6) begin
                stf.push_back(1'b0);
                ones = 0;
            end
        end
        lvl = 1'b1;
        foreach (stf[i]) begin
            if (!stf[i]) lvl = ~lvl;
            exp_q.push_back({lvl, ~lvl});
        end
        exp_q.push_back(2'b00);
        exp_q.push_back(2'b00);
        exp_q.push_back(2'b10);
    endtask

    // ---------------- driver tasks ----------------
    // Present a request and return at the falling edge just before the accept edge.
    task automatic drive_req(input logic [1:0] k, input logic [3:0] p, input logic [3:0] e,
                             input logic [LEN_W-1:0] l, input logic [DW-1:0] d, output bit ok);
        req_kind  = k;
        req_pid   = p;
        req_endp  = e;
        req_len   = l;
        req_data  = d;
        req_valid = 1'b1;
        ok        = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (req_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clock);
        end
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL accept_wait: req_ready stayed 0, required 1 within 300 cycles");
            req_valid = 1'b0;
            exp_q.delete();
        end
    endtask

    // Compare every busy cycle against exp_q, then the idle cycle after done.
    task automatic monitor_pkt(input string name, input int exp_cycles, input bit hold);
        logic [1:0] e;
        bit         last;
        int         cyc;
        int         busy_cnt;
        cyc      = 0;
        busy_cnt = 0;
        while (exp_q.size() > 0) begin
            @(negedge clock);
            e    = exp_q.pop_front();
            last = (exp_q.size() == 0);
            cyc++;
            if (busy) busy_cnt++;
            check(name, 32'({DP, DM, busy, done, req_ready}), 32'({e, 1'b1, last, 1'b0}));
            if (cyc == 1) begin
                if (hold) begin
                    req_kind = stage_kind;
                    req_pid  = stage_pid;
                    req_endp = stage_endp;
                    req_len  = stage_len;
                    req_data = stage_data;
                end else begin
                    req_valid = 1'b0;
                    req_kind  = 2'($urandom);
                    req_data  = '0;
                end
            end
        end
        if (exp_cycles > 0) check({name, "_cycles"}, 32'(busy_cnt), 32'(exp_cycles));
        @(negedge clock);
        check({name, "_idle"}, 32'({DP, DM, busy, done, req_ready}), 32'(5'b10001));
    endtask

    task automatic run_pkt(input string name, input logic [1:0] k, input logic [3:0] p,
                           input logic [3:0] e, input logic [LEN_W-1:0] l,
                           input logic [DW-1:0] d, input int exp_cycles);
        bit ok;
        build_expected(k, p, e, int'(l), d);
        drive_req(k, p, e, l, d, ok);
        if (ok) monitor_pkt(name, exp_cycles, 1'b0);
    endtask

    // ---------------- vector table ----------------
    typedef struct packed {
        logic [1:0]       kind;
        logic [3:0]       pid;
        logic [3:0]       endp;
        logic [LEN_W-1:0] len;
        logic [DW-1:0]    data;
        logic [15:0]      exp_cycles;   // 0: length checked by the model only
    } vec_t;

    vec_t       vecs[9];
    logic [1:0] e_tmp;
    logic [DW-1:0] rdata;
    bit         ok_main;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n   = 1'b0;
        req_valid = 1'b0;
        req_kind  = 2'b00;
        req_pid   = 4'h0;
        req_endp  = 4'h0;
        req_len   = '0;
        req_data  = '0;
`ifdef DATA_TOGGLE_EN
        toggle_adv = 1'b0;
        toggle_clr = 1'b0;
`endif
        //            kind   pid      endp   len            data                     cycles
        vecs[0] = '{2'b00, 4'b0010, 4'h0, LEN_W'(0),  DW'(0),                   16'd19}; // ACK
        vecs[1] = '{2'b01, 4'b0001, 4'h0, LEN_W'(0),  DW'(0),                   16'd35}; // OUT ep0
        vecs[2] = '{2'b10, 4'b0011, 4'h0, LEN_W'(0),  DW'(0),                   16'd35}; // ZLP DATA0
        vecs[3] = '{2'b10, 4'b1011, 4'h0, LEN_W'(1),  DW'(8'hff),               16'd0};  // stuffed payload
        vecs[4] = '{2'b10, 4'b0011, 4'h0, LEN_W'(TB_MAX + 3), DW'(64'h0123456789abcdef), 16'd0}; // clamp
        vecs[5] = '{2'b11, 4'b1010, 4'h0, LEN_W'(5),  DW'(64'hffffffff),        16'd19}; // kind 11 = hs
        vecs[6] = '{2'b01, 4'b1101, 4'hf, LEN_W'(0),  DW'(0),                   16'd0};  // SETUP ep15
        vecs[7] = '{2'b00, 4'b1110, 4'h0, LEN_W'(0),  DW'(0),                   16'd19}; // STALL
        vecs[8] = '{2'b01, 4'b1001, 4'h3, LEN_W'(0),  DW'(0),                   16'd0};  // IN ep3

        // reset state
        repeat (2) @(negedge clock);
        check("reset_state", 32'({DP, DM, busy, done, req_ready}), 32'(5'b10001));
        reset_n = 1'b1;
        @(negedge clock);
        check("post_reset_idle", 32'({DP, DM, busy, done, req_ready}), 32'(5'b10001));

        // table-driven vectors
        for (int i = 0; i < 9; i++) begin
            run_pkt($sformatf("vec%0d", i), vecs[i].kind, vecs[i].pid, vecs[i].endp,
                    vecs[i].len, vecs[i].data, int'(vecs[i].exp_cycles));
        end

        // randomized packets against the model
        for (int i = 0; i < 40; i++) begin
            for (int b = 0; b < TB_MAX; b++) rdata[8*b +: 8] = 8'($urandom);
            if ($urandom_range(0, 3) == 0) rdata = '1;
            run_pkt($sformatf("rnd%0d", i), 2'($urandom_range(0, 3)), 4'($urandom),
                    4'($urandom), LEN_W'($urandom_range(0, TB_MAX + 3)), rdata, 0);
        end

        // request held through busy: second accepted the cycle after done
        stage_kind = 2'b01;
        stage_pid  = 4'b1001;
        stage_endp = 4'h6;
        stage_len  = '0;
        stage_data = '0;
        build_expected(2'b00, 4'b0010, 4'h0, 0, '0);
        drive_req(2'b00, 4'b0010, 4'h0, '0, '0, ok_main);
        if (ok_main) begin
            monitor_pkt("hold_a", 19, 1'b1);
            build_expected(stage_kind, stage_pid, stage_endp, 0, '0);
            monitor_pkt("hold_b", 0, 1'b0);
        end

        // reset asserted mid-DATA
        for (int b = 0; b < TB_MAX; b++) rdata[8*b +: 8] = 8'($urandom);
        build_expected(2'b10, 4'b0011, 4'h0, TB_MAX, rdata);
        drive_req(2'b10, 4'b0011, 4'h0, LEN_W'(TB_MAX), rdata, ok_main);
        if (ok_main) begin
            for (int i = 0; i < 40; i++) begin
                @(negedge clock);
                e_tmp = exp_q.pop_front();
                check("rst_pre", 32'({DP, DM, busy, done}), 32'({e_tmp, 2'b10}));
                if (i == 0) req_valid = 1'b0;
            end
            reset_n = 1'b0;
            #1;
            check("rst_async", 32'({DP, DM, busy, done, req_ready}), 32'(5'b10001));
            for (int i = 0; i < 3; i++) begin
                @(negedge clock);
                check("rst_hold", 32'({DP, DM, busy, done, req_ready}), 32'(5'b10001));
            end
            reset_n = 1'b1;
            exp_q.delete();
            mdl_tog = 1'b0;
            @(negedge clock);
            run_pkt("after_rst", 2'b00, 4'b0010, 4'h0, '0, '0, 19);
        end

`ifdef DATA_TOGGLE_EN
        // DATA0, advance, DATA1, clear (with advance) -> DATA0
        run_pkt("tog_d0", 2'b10, 4'b0000, 4'h0, '0, '0, 35);
        toggle_adv = 1'b1;
        @(negedge clock);
        toggle_adv = 1'b0;
        mdl_tog    = ~mdl_tog;
        run_pkt("tog_d1", 2'b10, 4'b0000, 4'h0, '0, '0, 0);
        toggle_adv = 1'b1;
        toggle_clr = 1'b1;
        @(negedge clock);
        toggle_adv = 1'b0;
        toggle_clr = 1'b0;
        mdl_tog    = 1'b0;
        run_pkt("tog_clr", 2'b10, 4'b1111, 4'h0, '0, '0, 35);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
